// File: rtl/fib_seq_engine_pkg.sv
// fib_pkg: shared state and mode types for fib_seq_engine.
package fib_pkg;
  typedef enum logic {IDLE, RUN} fib_state_e;
  typedef enum logic {FIB_SINGLE, FIB_STREAM} fib_mode_e;
endpackage

// File: rtl/fib_seq_engine_if.sv
// fib_seq_engine_if: request strobe plus valid/ready term stream of fib_seq_engine.
interface fib_seq_engine_if #(parameter int WIDTH = 32, parameter int N_WIDTH = 8);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic               mode;
  logic               ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic [N_WIDTH-1:0] out_index;
  logic               out_last;
  logic               overflow;
  modport master (
    output start, n, mode, out_ready,
    input  ready, out_valid, out, out_index, out_last, overflow
  );
  modport slave (
    input  start, n, mode, out_ready,
    output ready, out_valid, out, out_index, out_last, overflow
  );
endinterface

// File: rtl/fib_seq_engine_adder.sv
// fib_adder: WIDTH-bit a+b with carry out; saturates to all-ones when FIB_SATURATE_EN is defined.
module fib_adder #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  logic [WIDTH:0] w_full;
  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[WIDTH];
`ifdef FIB_SATURATE_EN
  assign o_sum = o_carry ? '1 : w_full[WIDTH-1:0];
`else
  assign o_sum = w_full[WIDTH-1:0];
`endif
endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: Fibonacci term engine returning F(n) or F(0)..F(n) over valid/ready.
// Build option FIB_SATURATE_EN selects saturating instead of wrapping addition.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  fib_seq_engine_if.slave   bus
);
  fib_state_e         r_state, w_next;
  fib_mode_e          r_mode;
  logic [WIDTH-1:0]   r_a, r_b, w_sum;
  logic [N_WIDTH-1:0] r_k, r_n;
  logic               r_a_ovf, r_b_ovf, w_carry;
  logic               w_run, w_last, w_valid, w_adv, w_accept;
  fib_adder #(.WIDTH(WIDTH)) u_add (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );
  assign w_run    = r_state == RUN;
  assign w_last   = w_run && r_k == r_n;
  assign w_valid  = w_run && (r_mode == FIB_STREAM || w_last);
  assign w_adv    = w_run && (!w_valid || bus.out_ready);
  assign w_accept = !w_run && bus.start;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept)
      w_next = RUN;
    else if (w_adv && w_last)
      w_next = IDLE;
  end
  // b runs one term ahead of a, so overflow of b is handed to a on each step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_mode  <= FIB_SINGLE;
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (w_accept) begin
      r_a     <= '0;
      r_b     <= WIDTH'(1);
      r_k     <= '0;
      r_n     <= bus.n;
      r_mode  <= fib_mode_e'(bus.mode);
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (w_adv && !w_last) begin
      r_a     <= r_b;
      r_b     <= w_sum;
      r_a_ovf <= r_b_ovf;
      r_b_ovf <= r_a_ovf | r_b_ovf | w_carry;
      r_k     <= r_k + 1'b1;
    end
  end
  assign bus.ready     = !w_run;
  assign bus.out_valid = w_valid;
  assign bus.out       = w_run ? r_a : '0;
  assign bus.out_index = w_run ? r_k : '0;
  assign bus.out_last  = w_last;
  assign bus.overflow  = w_run && r_a_ovf;
endmodule

// File: tb/tb_fib_seq_engine.sv
// tb_fib_seq_engine: scoreboard bench for fib_seq_engine at WIDTH=32 and WIDTH=64.
module tb_fib_seq_engine;
  typedef struct packed {
    logic [63:0] v;
    logic [7:0]  k;
    logic        l;
    logic        o;
  } term_t;
  logic clk = 1'b0;
  logic reset;
  int n_vec = 0;
  int n_bad = 0;
  term_t sb[$];
  term_t got;
  always #5 clk = ~clk;
  fib_seq_engine_if #(.WIDTH(32), .N_WIDTH(8)) b32();
  fib_seq_engine_if #(.WIDTH(64), .N_WIDTH(8)) b64();
  fib_seq_engine #(.WIDTH(32), .N_WIDTH(8)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  fib_seq_engine #(.WIDTH(64), .N_WIDTH(8)) dut64 (.clk(clk), .reset(reset), .bus(b64));

  // reference via wide arithmetic: true F(k), then reduced to w bits
  function automatic term_t model(int k, int w, bit last);
    logic [127:0] a, b, t, m;
    term_t r;
    a = 128'd0;
    b = 128'd1;
    m = (128'd1 << w) - 128'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    r.k = 8'(k);
    r.l = last;
    r.o = a > m;
`ifdef FIB_SATURATE_EN
    r.v = 64'(r.o ? m : (a & m));
`else
    r.v = 64'(a & m);
`endif
    return r;
  endfunction

  function automatic term_t obs32();
    term_t r;
    r.v = 64'(b32.out);
    r.k = b32.out_index;
    r.l = b32.out_last;
    r.o = b32.overflow;
    return r;
  endfunction

  task automatic go32(input int n, input bit mode);
    int c = 0;
    @(negedge clk);
    while (!b32.ready && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (!b32.ready) begin
      n_bad++;
      $display("FAIL go32_ready: ready=%0b required 1", b32.ready);
    end
    b32.start = 1'b1;
    b32.n     = 8'(n);
    b32.mode  = mode;
    if (mode) for (int i = 0; i <= n; i++) sb.push_back(model(i, 32, i == n));
    else sb.push_back(model(n, 32, 1'b1));
    @(negedge clk);
    b32.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({b32.ready, b32.out_valid, b32.out, b32.out_index, b32.out_last, b32.overflow} !== {1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: rdy=%0b vld=%0b out=%0h idx=%0d last=%0b ovf=%0b required 1 0 0 0 0 0",
               b32.ready, b32.out_valid, b32.out, b32.out_index, b32.out_last, b32.overflow);
    end
    n_vec++;
    if ({b64.ready, b64.out_valid, b64.out} !== {1'b1, 1'b0, 64'd0}) begin
      n_bad++;
      $display("FAIL reset64: rdy=%0b vld=%0b out=%0h required 1 0 0", b64.ready, b64.out_valid, b64.out);
    end
  endtask

  task automatic test_single_latency();
    int lat = 0;
    b32.out_ready = 1'b1;
    go32(10, 1'b0);
    n_vec++;
    if (b32.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy: ready=%0b required 0", b32.ready);
    end
    while (!b32.out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != 10) begin
      n_bad++;
      $display("FAIL single_latency: got %0d cycles required 10", lat);
    end
    got = obs32();
    n_vec++;
    if (got !== sb[0]) begin
      n_bad++;
      $display("FAIL single_n10: got %h required %h", got, sb[0]);
    end
    void'(sb.pop_front());
    @(negedge clk);
    n_vec++;
    if ({b32.ready, b32.out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_done: rdy=%0b vld=%0b required 1 0", b32.ready, b32.out_valid);
    end
  endtask

  task automatic test_width64();
    int c = 0;
    term_t e;
    b64.out_ready = 1'b1;
    @(negedge clk);
    b64.start = 1'b1;
    b64.n     = 8'd88;
    b64.mode  = 1'b0;
    e = model(88, 64, 1'b1);
    @(negedge clk);
    b64.start = 1'b0;
    while (!b64.out_valid && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if ({b64.out, b64.out_index, b64.out_last, b64.overflow} !== {e.v, e.k, e.l, e.o}) begin
      n_bad++;
      $display("FAIL w64_n88: out=%0d idx=%0d last=%0b ovf=%0b required %0d %0d %0b %0b",
               b64.out, b64.out_index, b64.out_last, b64.overflow, e.v, e.k, e.l, e.o);
    end
    n_vec++;
    if (e.v !== 64'd1100087778366101931) begin
      n_bad++;
      $display("FAIL w64_model: got %0d required 1100087778366101931", e.v);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    for (int n = 47; n <= 48; n++) begin
      b32.out_ready = 1'b1;
      go32(n, 1'b0);
      for (int c = 0; c < 300 && sb.size() > 0; c++) begin
        if (b32.out_valid) begin
          got = obs32();
          n_vec++;
          if (got !== sb[0]) begin
            n_bad++;
            $display("FAIL overflow_n%0d: got %h required %h", n, got, sb[0]);
          end
          void'(sb.pop_front());
        end
        @(negedge clk);
      end
      n_vec++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL overflow_timeout: %0d pending required 0", sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_stream_stall();
    b32.out_ready = 1'b0;
    go32(6, 1'b1);
    for (int c = 0; c < 300 && sb.size() > 0; c++) begin
      b32.out_ready = (c % 3) == 0;
      if (b32.out_valid) begin
        got = obs32();
        n_vec++;
        if (got !== sb[0]) begin
          n_bad++;
          $display("FAIL stream_term: got %h required %h", got, sb[0]);
        end
        if (b32.out_ready) void'(sb.pop_front());
      end
      @(negedge clk);
    end
    n_vec++;
    if (sb.size() != 0 || b32.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_end: pending=%0d vld=%0b required 0 0", sb.size(), b32.out_valid);
      sb.delete();
    end
  endtask

  task automatic test_n_zero();
    for (int m = 0; m < 2; m++) begin
      b32.out_ready = 1'b0;
      go32(0, m[0]);
      b32.start = 1'b1;
      b32.n     = 8'd5;
      for (int c = 0; c < 300 && sb.size() > 0; c++) begin
        b32.out_ready = c >= 2;
        if (c == 1) b32.start = 1'b0;
        if (b32.out_valid) begin
          got = obs32();
          n_vec++;
          if (got !== sb[0]) begin
            n_bad++;
            $display("FAIL nzero_mode%0d: got %h required %h", m, got, sb[0]);
          end
          if (b32.out_ready) void'(sb.pop_front());
        end
        @(negedge clk);
      end
      b32.start = 1'b0;
      n_vec++;
      if (sb.size() != 0 || {b32.out_valid, b32.ready} !== 2'b01) begin
        n_bad++;
        $display("FAIL nzero_end_mode%0d: pending=%0d vld=%0b rdy=%0b required 0 0 1",
                 m, sb.size(), b32.out_valid, b32.ready);
        sb.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    b32.out_ready = 1'b1;
    go32(6, 1'b1);
    while (!(b32.out_valid && b32.out_index == 8'd3) && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (b32.out_index !== 8'd3) begin
      n_bad++;
      $display("FAIL midreset_reach: idx=%0d required 3", b32.out_index);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    n_vec++;
    if ({b32.out_valid, b32.ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL midreset_state: vld=%0b rdy=%0b required 0 1", b32.out_valid, b32.ready);
    end
    go32(5, 1'b0);
    for (int k = 0; k < 300 && sb.size() > 0; k++) begin
      if (b32.out_valid) begin
        got = obs32();
        n_vec++;
        if (got !== sb[0]) begin
          n_bad++;
          $display("FAIL midreset_restart: got %h required %h", got, sb[0]);
        end
        void'(sb.pop_front());
      end
      @(negedge clk);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_timeout: %0d pending required 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    b32.start = 1'b0; b32.n = '0; b32.mode = 1'b0; b32.out_ready = 1'b0;
    b64.start = 1'b0; b64.n = '0; b64.mode = 1'b0; b64.out_ready = 1'b0;
    test_reset();
    test_single_latency();
    test_width64();
    test_overflow();
    test_stream_stall();
    test_n_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fib_seq_engine.md
# fib_seq_engine

Parametrised Fibonacci sequence engine, successor to the fixed 32-bit `FibonacciSeries` block. It accepts a request for term index n and returns either only F(n) or the full stream F(0)..F(n). Results leave through a valid/ready handshake, and each term carries an overflow flag. It sits behind a control/register front end and feeds downstream consumers that may apply back-pressure.

## Interface
Parameters:
- `WIDTH`, default 32: term width in bits.
- `N_WIDTH`, default 8: width of the index n.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request strobe; accepted only when `ready`=1.
- `n`, input, N_WIDTH: target index, captured on acceptance.
- `mode`, input, 1: 0 = single (F(n) only), 1 = stream (F(0)..F(n)); captured on acceptance.
- `ready`, output, 1: engine idle, can accept `start`.
- `out_valid`, output, 1: `out` holds a term to transfer.
- `out_ready`, input, 1: consumer accepts the term.
- `out`, output, WIDTH: term value.
- `out_index`, output, N_WIDTH: index k of the term on `out`.
- `out_last`, output, 1: term is F(n), the final transfer of the request.
- `overflow`, output, 1: the term on `out` exceeded 2^WIDTH−1.

## Operation
Definitions:
- F(0)=0, F(1)=1, F(k)=F(k−1)+F(k−2).
- Registers: a=F(k), b=F(k+1), k, n_r, mode_r, a_ovf, b_ovf.

FSM states are IDLE and RUN.
- IDLE: `ready`=1. `start`=1 at an edge loads a=0, b=1, k=0, a_ovf=b_ovf=0, n_r=n, mode_r=mode, then goes to RUN.
- RUN: `ready`=0 and `start` is ignored.
  - `out_valid` = mode_r | (k==n_r).
  - `out`=a, `out_index`=k, `out_last`=(k==n_r), `overflow`=a_ovf.
- Advance condition: !`out_valid` | `out_ready`.
  - If advancing with k==n_r, return to IDLE.
  - Otherwise advance a←b, b←a+b, a_ovf←b_ovf, b_ovf←(a_ovf|b_ovf|carry), k←k+1.
- Once set, overflow propagates to all later terms.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- n=0 produces exactly one transfer: F(0)=0 with `out_last`=1.
- Reset in any state, including mid-RUN or mid-stall, forces IDLE and drops the pending term.
- Reset values: `ready`=1, `out_valid`=0, `out`=0, `out_index`=0, `out_last`=0, `overflow`=0.

## Timing
- Outputs are registered-state decodes only; there is no combinational path from `out_ready`/`start` to any output.
- Single mode, no stall: with acceptance at edge E0, `out_valid` is high in the cycle after edge E0+n, so latency is n cycles from acceptance. `ready` returns the cycle after the handshake edge.
- Stream mode, `out_ready` tied high: one term per cycle, n+1 consecutive valid cycles.
- Throughput: back-to-back requests have a one-cycle IDLE bubble.

## Configuration
`FIB_SATURATE_EN`:
- Defined: an overflowing addition yields all-ones; all later terms stay all-ones with `overflow`=1.
- Undefined: addition wraps modulo 2^WIDTH; `overflow` is still flagged.

## Structure
- `fib_pkg`: `fib_state_e` {IDLE, RUN}; `fib_mode_e` {FIB_SINGLE, FIB_STREAM}.
- Sub-module `fib_adder`: WIDTH-bit add of a+b. Returns sum and carry; saturates under `FIB_SATURATE_EN`.
- Top level: FSM, registers and output decode.

## Test plan
- WIDTH=32, single, n=10, `out_ready`=1 → one transfer: `out`=55, `out_index`=10, `out_last`=1, `overflow`=0, 10 cycles after acceptance.
- WIDTH=64, single, n=88 → `out`=1100087778366101931, `overflow`=0.
- WIDTH=32, single, n=47 → 32'hB11924E1, `overflow`=0. Then n=48 → 32'h1E8D0A40 with `overflow`=1, or 32'hFFFFFFFF with `FIB_SATURATE_EN`.
- Stream, n=6, `out_ready` toggling 1,0,0,1,… → exactly the sequence 0,1,1,2,3,5,8. Indices are 0..6, values hold during stalls, and `out_last` is set only on 8.
- n=0, both modes → a single transfer of 0 with `out_last`=1. `start` pulsed during RUN is ignored.
- Reset asserted mid-stream at k=3 → next cycle `out_valid`=0 and `ready`=1. A new start with n=5 (single) yields 5.
